pmem_burst_adaptor: RTL and testbench
=====================================

// Module: pmem_burst_adaptor
// PURPOSE
//  Physical-memory-side responder for the cache's 256-bit line interface.
//  - Accepts one line read (fill) or line write (writeback) at a time.
//  - Each line moves as BEATS beats of BURST_W bits on a burst memory port.
//  - Returns a single-cycle pmem_resp to the cache when the line transfer completes.
//  - Sits between the cache and main memory.
// PARAMETERS
//  LINE_W   256  line width in bits; matches pmem_rdata/pmem_wdata
//  BURST_W  64   memory-side beat width in bits
//  BEATS    LINE_W/BURST_W (4)  beats per line
// PORTS
//  clk           in   1        single clock; all state changes on the rising edge
//  rst           in   1        reset; asynchronous, active-low
//  pmem_address  in   32       line address from the cache; bits [4:0] ignored
//  pmem_read     in   1        line read request; cache holds it until pmem_resp
//  pmem_write    in   1        line write request; cache holds it until pmem_resp
//  pmem_wdata    in   LINE_W   writeback line
//  pmem_rdata    out  LINE_W   fill line
//  pmem_resp     out  1        one-cycle completion pulse
//  mem_address   out  32       line-aligned burst address
//  mem_read      out  1        burst read request
//  mem_write     out  1        burst write request
//  mem_burst_o   out  BURST_W  write beat data
//  mem_burst_i   in   BURST_W  read beat data
//  mem_resp      in   1        memory beat strobe
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, beat count=0, all outputs 0.
//  - Reset mid-burst abandons the transfer; mem_read/mem_write drop immediately.
//  - No pmem_resp is issued for the abandoned transfer.
//  Registered outputs only:
//  - mem_read=1 only in RD; mem_write=1 only in WR.
//  - pmem_resp=1 only in DONE.
//  States: IDLE, RD, WR, DONE.
//  IDLE:
//  - pmem_write=1 -> WR. Write has priority if both requests are high.
//  - else pmem_read=1 -> RD.
//  - On the leaving edge, latch {pmem_address[31:5],5'b0} into mem_address.
//  - On a write, also latch pmem_wdata into the line buffer.
//  - Beat count is cleared. mem_resp is ignored in IDLE and DONE.
//  RD:
//  - Each cycle with mem_resp=1 stores mem_burst_i into buffer slice [cnt*BURST_W +: BURST_W].
//  - cnt increments on each such beat. Beat 0 is line bits [63:0].
//  - Cycles with mem_resp=0 are wait states; nothing changes.
//  - After beat BEATS-1 -> DONE.
//  WR:
//  - mem_burst_o = buffer slice cnt.
//  - mem_resp=1 accepts the beat; cnt increments and mem_burst_o shows the next slice the following cycle.
//  - After beat BEATS-1 -> DONE.
//  DONE:
//  - pmem_resp=1 for exactly one cycle, then IDLE.
//  - pmem_rdata equals the assembled line from the DONE cycle onward.
//  - pmem_rdata holds until the next read completes. A write never alters pmem_rdata.
//  Latency, zero memory wait states:
//  - Request seen at edge 0; beats occur in cycles 1..4; pmem_resp in cycle 5.
//  - The IDLE cycle after DONE gives the cache a cycle to drop its request.
//  Counter: cnt is log2(BEATS) bits; it wraps to 0 after the last beat.
//  Address: bits [4:0] of mem_address are always 0.
//  - mem_address is stable for the whole burst even if pmem_address changes.
// TESTING
//  1. Read, addr 0x0000_1234, mem_resp high 4 consecutive cycles, beats 0x11..11/0x22..22/0x33..33/0x44..44
//     -> mem_address=0x0000_1220; pmem_resp in cycle 5
//     -> pmem_rdata={44..,33..,22..,11..}
//  2. Write of 256'h{D,C,B,A} (64-bit words), mem_resp high 4 cycles
//     -> mem_write=1; mem_burst_o sequence A,B,C,D; one pmem_resp
//     -> pmem_rdata unchanged
//  3. Read with 2 wait cycles before each beat
//     -> beats captured only on mem_resp cycles; pmem_resp 13 cycles after request
//  4. pmem_read and pmem_write both high
//     -> WR burst taken; mem_read stays 0
//  5. rst low after beat 2 of a read
//     -> all outputs 0 asynchronously; after release, a new read completes normally
//  6. Back-to-back read then write
//     -> exactly one IDLE cycle between DONE and the next mem_write

Source files
------------

// File: rtl/pmem_burst_adaptor.sv
// pmem_burst_adaptor: turns one cache line request (fill or writeback) into a
// BEATS-beat burst on the memory port and returns a one-cycle pmem_resp.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   pmem_address      cache line address (offset bits ignored)
//   pmem_read/write   cache line requests, held until pmem_resp
//   pmem_wdata        writeback line
//   pmem_rdata        last completed fill line (held)
//   pmem_resp         one-cycle completion pulse
//   mem_address       line-aligned burst address
//   mem_read/write    burst request to memory
//   mem_burst_o       write beat data
//   mem_burst_i       read beat data
//   mem_resp          memory beat strobe
module pmem_burst_adaptor #(
  parameter  int unsigned LINE_W  = 256,
  parameter  int unsigned BURST_W = 64,
  localparam int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pmem_address,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [LINE_W-1:0] pmem_wdata,
  output logic [LINE_W-1:0] pmem_rdata,
  output logic              pmem_resp,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [BURST_W-1:0] mem_burst_o,
  input  logic [BURST_W-1:0] mem_burst_i,
  input  logic              mem_resp
);

  localparam int unsigned BEATS = LINE_W / BURST_W;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
  // Clears the byte-offset bits within a line
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_W / 8 - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [LINE_W-1:0]  line_q, line_n;
  logic [ADDR_W-1:0]  addr_n;
  logic [BURST_W-1:0] burst_n;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state, beat counter, line buffer and burst address
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    line_n  = line_q;
    addr_n  = mem_address;
    burst_n = '0;

    unique case (state)
      IDLE: begin
        cnt_n = '0;
        // Write wins when both requests are high
        if (pmem_write) begin
          state_n = WR;
          addr_n  = pmem_address & LINE_MASK;
          line_n  = pmem_wdata;
        end else if (pmem_read) begin
          state_n = RD;
          addr_n  = pmem_address & LINE_MASK;
        end
      end

      RD: begin
        if (mem_resp) begin
          for (int unsigned i = 0; i < BEATS; i++) begin
            if (cnt == CNT_W'(i)) begin
              line_n[i*BURST_W +: BURST_W] = mem_burst_i;
            end
          end
          cnt_n = cnt + CNT_W'(1);
          if (cnt == LAST_BEAT) begin
            state_n = DONE;
          end
        end
      end

      WR: begin
        if (mem_resp) begin
          cnt_n = cnt + CNT_W'(1);
          if (cnt == LAST_BEAT) begin
            state_n = DONE;
          end
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    // Beat data presented for the upcoming write cycle
    if (state_n == WR) begin
      for (int unsigned i = 0; i < BEATS; i++) begin
        if (cnt_n == CNT_W'(i)) begin
          burst_n = line_n[i*BURST_W +: BURST_W];
        end
      end
    end
  end

  // Datapath and registered outputs, all derived from next-state values
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      line_q      <= '0;
      mem_address <= '0;
      mem_burst_o <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      pmem_resp   <= 1'b0;
      pmem_rdata  <= '0;
    end else begin
      cnt         <= cnt_n;
      line_q      <= line_n;
      mem_address <= addr_n;
      mem_burst_o <= burst_n;
      mem_read    <= (state_n == RD);
      mem_write   <= (state_n == WR);
      pmem_resp   <= (state_n == DONE);
      // Only a completed fill updates the cache-visible line
      if ((state == RD) && (state_n == DONE)) begin
        pmem_rdata <= line_n;
      end
    end
  end

endmodule

// File: tb/tb_pmem_burst_adaptor.sv
// Bench for pmem_burst_adaptor: a driver acting as the cache, a memory
// responder with configurable wait states, and a response monitor fed by a
// scoreboard queue filled at issue time.
`timescale 1ns/1ps
module tb_pmem_burst_adaptor;

  localparam int unsigned LINE_W  = 256;
  localparam int unsigned BURST_W = 64;
  localparam int unsigned BEATS   = LINE_W / BURST_W;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [31:0]        pmem_address = '0;
  logic               pmem_read = 1'b0;
  logic               pmem_write = 1'b0;
  logic [LINE_W-1:0]  pmem_wdata = '0;
  logic [LINE_W-1:0]  pmem_rdata;
  logic               pmem_resp;
  logic [31:0]        mem_address;
  logic               mem_read;
  logic               mem_write;
  logic [BURST_W-1:0] mem_burst_o;
  logic [BURST_W-1:0] mem_burst_i = '0;
  logic               mem_resp = 1'b0;

  pmem_burst_adaptor #(.LINE_W(LINE_W), .BURST_W(BURST_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .mem_address  (mem_address),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_burst_o  (mem_burst_o),
    .mem_burst_i  (mem_burst_i),
    .mem_resp     (mem_resp)
  );

  always #5 clk = ~clk;

  typedef struct { logic [LINE_W-1:0] rdata; int lat; } resp_t;
  typedef struct { logic is_wr; logic [31:0] addr; } burst_t;

  resp_t              resp_q[$];
  burst_t             burst_q[$];
  logic [BURST_W-1:0] rd_beats_q[$];
  logic [BURST_W-1:0] wr_beats_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int req_cyc = 0;
  int done_cyc = 0;
  int cur_waits = 0;
  bit b2b_chk = 1'b0;
  logic [LINE_W-1:0] ref_rdata = '0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Cache-side driver: one request at a time, held until pmem_resp
  task automatic issue(input bit is_wr, input bit both, input logic [31:0] addr,
                       input logic [LINE_W-1:0] ln, input int waits);
    resp_t  r;
    burst_t b;
    bit     done = 1'b0;
    b.is_wr = is_wr;
    b.addr  = (addr >> 5) << 5;
    burst_q.push_back(b);
    for (int i = 0; i < BEATS; i++) begin
      if (is_wr) wr_beats_q.push_back(ln[i*BURST_W +: BURST_W]);
      else       rd_beats_q.push_back(ln[i*BURST_W +: BURST_W]);
    end
    if (!is_wr) ref_rdata = ln;
    r.rdata = ref_rdata;
    r.lat   = 1 + BEATS * (waits + 1);
    resp_q.push_back(r);

    @(negedge clk);
    cur_waits    = waits;
    pmem_address = addr;
    pmem_wdata   = is_wr ? ln : rand_line();
    pmem_write   = is_wr;
    pmem_read    = !is_wr || both;
    req_cyc      = cyc;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      if (pmem_resp) done = 1'b1;
      else begin
        // Address and data may wander once the request has been taken
        pmem_address = $urandom;
        pmem_wdata   = rand_line();
      end
    end
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    if (!done) begin
      check_int("resp_timeout", 0, 1);
      finish_run();
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_pmem_rdata"}, pmem_rdata, '0);
    check({tag, "_pmem_resp"}, LINE_W'(pmem_resp), '0);
    check({tag, "_mem_address"}, LINE_W'(mem_address), '0);
    check({tag, "_mem_read"}, LINE_W'(mem_read), '0);
    check({tag, "_mem_write"}, LINE_W'(mem_write), '0);
    check({tag, "_mem_burst_o"}, LINE_W'(mem_burst_o), '0);
  endtask

  // Read abandoned by reset after two beats; no pmem_resp expected
  task automatic reset_mid_read();
    burst_t b;
    logic [LINE_W-1:0] ln = rand_line();
    b.is_wr = 1'b0;
    b.addr  = 32'h0000_5A40;
    burst_q.push_back(b);
    for (int i = 0; i < BEATS; i++) rd_beats_q.push_back(ln[i*BURST_W +: BURST_W]);
    @(negedge clk);
    cur_waits    = 0;
    pmem_address = 32'h0000_5A5C;
    pmem_read    = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1 check_outputs_zero("midreset");
    pmem_read = 1'b0;
    ref_rdata = '0;
    rd_beats_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Memory-side responder and burst checker
  bit             in_burst = 1'b0;
  int             wait_left = 0;
  logic [31:0]    burst_addr = '0;
  always @(negedge clk) begin
    burst_t b;
    if (!rst) begin
      in_burst    = 1'b0;
      wait_left   = 0;
      mem_resp    = 1'b0;
      mem_burst_i = '0;
    end else if (mem_read || mem_write) begin
      if (!in_burst) begin
        in_burst  = 1'b1;
        wait_left = cur_waits;
        if (burst_q.size() == 0) begin
          check_int("unexpected_burst", 1, 0);
          b.is_wr = mem_write;
          b.addr  = mem_address;
        end else b = burst_q.pop_front();
        burst_addr = b.addr;
        check("burst_kind_write", LINE_W'(mem_write), LINE_W'(b.is_wr));
        check("burst_kind_read", LINE_W'(mem_read), LINE_W'(!b.is_wr));
        if (b2b_chk) begin
          check_int("b2b_gap", cyc - done_cyc, 2);
          b2b_chk = 1'b0;
        end
      end
      check("mem_address", LINE_W'(mem_address), LINE_W'(burst_addr));
      if (wait_left > 0) begin
        mem_resp    = 1'b0;
        mem_burst_i = $urandom;
        wait_left--;
      end else begin
        mem_resp  = 1'b1;
        wait_left = cur_waits;
        if (mem_write) begin
          mem_burst_i = {$urandom, $urandom};
          if (wr_beats_q.size() == 0) check_int("wr_beat_extra", 1, 0);
          else check("mem_burst_o", LINE_W'(mem_burst_o), LINE_W'(wr_beats_q.pop_front()));
        end else begin
          if (rd_beats_q.size() == 0) begin
            check_int("rd_beat_extra", 1, 0);
            mem_burst_i = '0;
          end else mem_burst_i = rd_beats_q.pop_front();
        end
      end
    end else begin
      // Strobe noise outside a burst must be ignored
      in_burst    = 1'b0;
      mem_resp    = 1'($urandom_range(0, 1));
      mem_burst_i = {$urandom, $urandom};
    end
  end

  // Completion monitor
  bit prev_resp = 1'b0;
  always @(negedge clk) begin
    resp_t r;
    if (rst) begin
      if (pmem_resp) begin
        done_cyc = cyc;
        check_int("resp_single_cycle", int'(prev_resp), 0);
        if (resp_q.size() == 0) check_int("unexpected_resp", 1, 0);
        else begin
          r = resp_q.pop_front();
          check("pmem_rdata", pmem_rdata, r.rdata);
          check_int("latency", cyc - req_cyc, r.lat);
        end
      end
      prev_resp = pmem_resp;
    end else prev_resp = 1'b0;
  end

  initial begin
    #200000;
    check_int("watchdog", 0, 1);
    finish_run();
  end

  initial begin
    logic [63:0] wa, wb, wc, wd;
    logic [LINE_W-1:0] ln;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b1;

    // Fill with fixed beat patterns
    ln = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    issue(1'b0, 1'b0, 32'h0000_1234, ln, 0);
    check("fill_pattern", pmem_rdata, ln);

    // Writeback; beats A,B,C,D and pmem_rdata untouched
    wa = 64'hAAAA_AAAA_AAAA_AAAA; wb = 64'hBBBB_BBBB_BBBB_BBBB;
    wc = 64'hCCCC_CCCC_CCCC_CCCC; wd = 64'hDDDD_DDDD_DDDD_DDDD;
    issue(1'b1, 1'b0, 32'h0000_2000, {wd, wc, wb, wa}, 0);

    // Fill with two wait states per beat
    issue(1'b0, 1'b0, 32'h0000_3050, rand_line(), 2);

    // Both requests high: write wins
    issue(1'b1, 1'b1, 32'hFFFF_FFFF, rand_line(), 1);

    reset_mid_read();
    issue(1'b0, 1'b0, 32'h0000_6040, rand_line(), 0);

    // Back-to-back fill then writeback
    issue(1'b0, 1'b0, 32'h0001_0000, rand_line(), 0);
    b2b_chk = 1'b1;
    issue(1'b1, 1'b0, 32'h0001_0020, rand_line(), 0);

    for (int t = 0; t < 40; t++) begin
      bit wr = 1'($urandom_range(0, 1));
      bit bo = wr && ($urandom_range(0, 3) == 0);
      issue(wr, bo, $urandom, rand_line(), $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check_int("resp_queue_drained", resp_q.size(), 0);
    finish_run();
  end

endmodule
